// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N:1 round-robin arbitrating mux with a single registered output stage
// Define ARB_MUX_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rr pointer).
module rr_arb_mux #(
   parameter int NUM_CH = 32,
   parameter int WIDTH  = 32,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   input  logic                    out_ready
);

   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    out_data_q,  out_data_d;
   logic [SEL_W-1:0]    out_sel_q,   out_sel_d;
   logic [SEL_W-1:0]    base;
   logic [SEL_W-1:0]    grant_idx;
   logic                grant_any;
   logic [NUM_CH-1:0]   grant;
   logic                load;
   logic                xfer;

`ifdef ARB_MUX_FIXED_PRIO_EN
   assign base = '0;
`else
   logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
   assign base = rr_ptr_q;
`endif

   // Scan from base upward with wraparound; the first valid channel wins.
   always_comb begin : arb
      int               idx;
      logic [SEL_W-1:0] cand;
      idx       = 0;
      cand      = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int off = 0; off < NUM_CH; off++) begin
         idx = int'(base) + off;
         if (idx >= NUM_CH) begin
            idx = idx - NUM_CH;
         end
         cand = SEL_W'(idx);
         if (!grant_any && in_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
      grant = '0;
      if (grant_any) begin
         grant[grant_idx] = 1'b1;
      end
   end

   assign load     = !out_valid_q || out_ready;
   assign in_ready = grant & {NUM_CH{load && !rst}};
   assign xfer     = grant_any && load && !rst;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
         out_sel_d   = grant_idx;
      end else if (load) begin
         out_valid_d = 1'b0;
      end
   end

`ifndef ARB_MUX_FIXED_PRIO_EN
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (xfer) begin
         rr_ptr_d = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - directed self-checking bench for rr_arb_mux (NUM_CH=4, WIDTH=32)
module tb_rr_arb_mux;

   localparam int NUM_CH = 4;
   localparam int WIDTH  = 32;
   localparam int SEL_W  = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_ready;
   logic                    out_valid;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_sel;
   logic                    out_ready;

   int checks = 0;
   int errors = 0;

   rr_arb_mux #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] s);
      chk({tag, "_valid"}, 32'(out_valid), 32'(v));
      chk({tag, "_data"},  out_data, d);
      chk({tag, "_sel"},   32'(out_sel), 32'(s));
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 4'b1111;
      in_data   = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
      out_ready = 1'b0;
      tick();
      tick();
      chk_out("reset", 1'b0, 32'h0, 2'd0);
      chk("reset_in_ready", 32'(in_ready), 32'h0);

`ifdef ARB_MUX_FIXED_PRIO_EN
      rst       = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("fp_in_ready", 32'(in_ready), 32'h1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_out("fp_beat", 1'b1, 32'h1000_0000, 2'd0);
         chk("fp_in_ready_k", 32'(in_ready), 32'h1);
      end
`else
      // Single requester on ch2
      rst       = 1'b0;
      in_valid  = 4'b0100;
      in_data   = {32'hDEAD_0003, 32'hA5A5_0002, 32'hDEAD_0001, 32'hDEAD_0000};
      out_ready = 1'b1;
      #1;
      chk("single_in_ready", 32'(in_ready), 32'h4);
      tick();
      chk_out("single", 1'b1, 32'hA5A5_0002, 2'd2);

      // Nothing valid: output empties, data/sel hold
      in_valid = 4'b0000;
      #1;
      chk("idle_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk_out("idle", 1'b0, 32'hA5A5_0002, 2'd2);

      // Reset to restart the pointer at 0
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 4'b1111;
      in_data  = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
      #1;
      chk("all_in_ready0", 32'(in_ready), 32'h1);
      tick();
      chk_out("all0", 1'b1, 32'h1000_0000, 2'd0);
      chk("all_in_ready1", 32'(in_ready), 32'h2);
      tick();
      chk_out("all1", 1'b1, 32'h1000_0001, 2'd1);
      chk("all_in_ready2", 32'(in_ready), 32'h4);
      tick();
      chk_out("all2", 1'b1, 32'h1000_0002, 2'd2);
      chk("all_in_ready3", 32'(in_ready), 32'h8);
      tick();
      chk_out("all3", 1'b1, 32'h1000_0003, 2'd3);
      chk("all_in_ready4", 32'(in_ready), 32'h1);
      tick();
      chk_out("all4_wrap", 1'b1, 32'h1000_0000, 2'd0);
      tick();
      chk_out("pre_bp", 1'b1, 32'h1000_0001, 2'd1);

      // Backpressure for 3 cycles
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'h0);
         tick();
         chk_out("bp_hold", 1'b1, 32'h1000_0001, 2'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 32'(in_ready), 32'h4);
      tick();
      chk_out("bp_release", 1'b1, 32'h1000_0002, 2'd2);
      tick();
      chk_out("pre_rst", 1'b1, 32'h1000_0003, 2'd3);

      // Reset mid-stream
      rst = 1'b1;
      #1;
      chk("rst_mid_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk_out("rst_mid", 1'b0, 32'h0, 2'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'h1);
      tick();
      chk_out("post_rst", 1'b1, 32'h1000_0000, 2'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
